// File: rtl/fifo_stream_drain_pkg.sv
// Shared constants and width helpers for the FIFO read-side drain stage.
package fifo_stream_drain_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

  // Index width for a counter over n values; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Occupancy counter width able to hold the value depth itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Credit sum (count + inflight) needs one bit of headroom over occupancy.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/fifo_stream_drain_buf.sv
// Small circular output buffer: registered storage, head read from a flop mux.
module stream_buf
  import fifo_stream_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       head,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = idx_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side drain of the synchronous FIFO: credit-based pops into a small
// buffer, presented as a valid/ready stream framed into fixed-length packets.
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int PKT_LEN    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      pkt_count,
  output logic                  idle
);

  localparam int CW = cnt_width(BUF_DEPTH);
  localparam int KW = credit_width(BUF_DEPTH);
  localparam int BW = idx_width(PKT_LEN);

  logic [CW-1:0]         count;
  logic [KW-1:0]         used;
  logic [BW-1:0]         beat_idx;
  logic [DATA_WIDTH-1:0] head;
  logic                  inflight;
  logic                  pop;
  logic                  issue;

  // A pop always has count >= 1, so the subtraction cannot underflow.
  assign pop   = m_valid && m_ready;
  assign used  = KW'(count) + KW'(inflight) - KW'(pop);
  assign issue = !fifo_empty && !rst && (used < KW'(BUF_DEPTH));

  assign fifo_rd_en = issue;

  stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign m_valid = (count != '0);
  assign m_data  = head;
  assign m_last  = m_valid && (beat_idx == BW'(PKT_LEN - 1));
  assign idle    = !inflight && (count == '0) && fifo_empty;

  // Read data lands one cycle after the request; track the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= issue;
  end

  // Beat position within the packet and completed-packet tally, advanced on pops only.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx  <= '0;
      pkt_count <= '0;
    end else if (pop) begin
      if (m_last) begin
        beat_idx  <= '0;
        pkt_count <= pkt_count + 1'b1;
      end else begin
        beat_idx  <= beat_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Randomized self-checking bench for fifo_stream_drain with a queue-level model.
module tb_fifo_stream_drain;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int PLEN  = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] pkt_count;
  logic          idle;

  fifo_stream_drain #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (DEPTH),
    .PKT_LEN    (PLEN),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .pkt_count  (pkt_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // upstream FIFO contents and reference model state
  logic [DW-1:0] fifo_mem [$];
  logic [DW-1:0] mq [$];
  bit            m_infl;
  logic [DW-1:0] m_word;
  int            beat;
  logic [CW-1:0] pkts;

  // observations
  logic [DW-1:0] got [$];
  bit            got_last [$];
  int            pop_cyc [$];
  int            rd_count;
  int            dut_occ;
  int            first_rd;
  int            first_v;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit pop_m, iss_m, rd, popd;
    int occ;
    fifo_empty = (fifo_mem.size() == 0);
    #1;
    pop_m = (mq.size() != 0) && m_ready;
    occ   = mq.size() + int'(m_infl) - int'(pop_m);
    iss_m = !fifo_empty && !rst && (occ < DEPTH);
    chk("m_valid", int'(m_valid), int'(mq.size() != 0));
    if (mq.size() != 0) chk("m_data", int'(m_data), int'(mq[0]));
    chk("m_last", int'(m_last), int'((mq.size() != 0) && (beat == PLEN - 1)));
    chk("fifo_rd_en", int'(fifo_rd_en), int'(iss_m));
    chk("pkt_count", int'(pkt_count), int'(pkts));
    chk("idle", int'(idle), int'(!m_infl && (mq.size() == 0) && fifo_empty));
    if (fifo_rd_en && fifo_empty) chk("overread", 1, 0);
    rd   = fifo_rd_en;
    popd = m_valid && m_ready;
    if (rd && first_rd < 0) first_rd = cyc;
    if (m_valid && first_v < 0) first_v = cyc;
    if (popd && !rst) begin
      got.push_back(m_data);
      got_last.push_back(m_last);
      pop_cyc.push_back(cyc);
      dut_occ--;
    end
    if (rd) begin
      rd_count++;
      dut_occ++;
    end
    if (dut_occ > DEPTH) chk("occupancy", dut_occ, DEPTH);
    if (rst) begin
      mq.delete();
      m_infl  = 0;
      beat    = 0;
      pkts    = '0;
      dut_occ = 0;
    end else begin
      if (pop_m) begin
        void'(mq.pop_front());
        if (beat == PLEN - 1) begin
          beat = 0;
          pkts = pkts + 1'b1;
        end else beat++;
      end
      if (m_infl) mq.push_back(m_word);
      m_infl = iss_m;
      if (iss_m) m_word = fifo_mem[0];
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rd && !fifo_empty) fifo_dout = fifo_mem.pop_front();
    else fifo_dout = DW'($urandom);
    if (rst) fifo_mem.delete();
  endtask

  task automatic clear_obs();
    got.delete();
    got_last.delete();
    pop_cyc.delete();
    rd_count = 0;
    first_rd = -1;
    first_v  = -1;
  endtask

  task automatic run_until_got(input int n, input int limit, input string name);
    int k = 0;
    while (got.size() < n && k < limit) begin
      step();
      k++;
    end
    if (got.size() < n) chk({name, "_timeout"}, got.size(), n);
  endtask

  task automatic settle(input int limit);
    int k = 0;
    while (!(fifo_mem.size() == 0 && mq.size() == 0 && !m_infl) && k < limit) begin
      step();
      k++;
    end
    if (k >= limit) chk("settle_timeout", k, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_w [$];
    int p0;
    rst       = 1'b1;
    m_ready   = 1'b0;
    fifo_dout = '0;
    m_infl    = 0;
    m_word    = '0;
    beat      = 0;
    pkts      = '0;
    dut_occ   = 0;
    clear_obs();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) step();
    chk("t1_rd_en", int'(fifo_rd_en), 0);
    chk("t1_valid", int'(m_valid), 0);
    chk("t1_idle", int'(idle), 1);
    chk("t1_pkt", int'(pkt_count), 0);

    // 2: eight words, consumer always ready
    clear_obs();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_mem.push_back(DW'(i));
    run_until_got(8, 40, "t2");
    settle(20);
    chk("t2_latency", first_v - first_rd, 2);
    for (int i = 0; i < got.size(); i++) begin
      chk("t2_data", int'(got[i]), i + 1);
      chk("t2_last", int'(got_last[i]), int'(i == 3 || i == 7));
    end
    if (pop_cyc.size() == 8) chk("t2_back2back", pop_cyc[7] - pop_cyc[0], 7);
    chk("t2_pkt", int'(pkt_count), 2);
    chk("t2_idle", int'(idle), 1);

    // 3: 16 words, ready pattern 1,0,0,1
    clear_obs();
    exp_w.delete();
    for (int i = 0; i < 16; i++) begin
      exp_w.push_back(DW'($urandom));
      fifo_mem.push_back(exp_w[i]);
    end
    begin
      int k = 0;
      while (got.size() < 16 && k < 200) begin
        m_ready = ((k % 4) == 0) || ((k % 4) == 3);
        step();
        k++;
      end
      if (got.size() < 16) chk("t3_timeout", got.size(), 16);
    end
    m_ready = 1'b1;
    settle(20);
    chk("t3_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t3_data", int'(got[i]), int'(exp_w[i]));

    // 4: backpressure with a full FIFO, then release
    clear_obs();
    exp_w.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_w.push_back(DW'(8'h40 + i));
      fifo_mem.push_back(exp_w[i]);
    end
    for (int i = 0; i < 20; i++) step();
    chk("t4_reads", rd_count, DEPTH);
    chk("t4_hold", int'(m_data), int'(exp_w[0]));
    chk("t4_valid", int'(m_valid), 1);
    m_ready = 1'b1;
    run_until_got(16, 60, "t4");
    settle(20);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t4_data", int'(got[i]), int'(exp_w[i]));
    if (pop_cyc.size() == 16) chk("t4_back2back", pop_cyc[15] - pop_cyc[0], 15);

    // 5: packet split by an empty gap
    clear_obs();
    p0 = int'(pkt_count);
    fifo_mem.push_back(8'hC0);
    fifo_mem.push_back(8'hC1);
    for (int i = 0; i < 8; i++) step();
    chk("t5_gap_valid", int'(m_valid), 0);
    fifo_mem.push_back(8'hC2);
    fifo_mem.push_back(8'hC3);
    settle(20);
    chk("t5_beats", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t5_last", int'(got_last[i]), int'(i == 3));
    chk("t5_pkt", int'(pkt_count) - p0, 1);

    // 6: reset mid-packet with buffered and in-flight words
    clear_obs();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) fifo_mem.push_back(DW'(8'h90 + i));
    for (int i = 0; i < 3; i++) step();
    m_ready = 1'b0;
    step();
    chk("t6_pre_valid", int'(m_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", int'(m_valid), 0);
    chk("t6_pkt", int'(pkt_count), 0);
    clear_obs();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_mem.push_back(DW'(8'hA0 + i));
    settle(30);
    chk("t6_beats", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("t6_data", int'(got[i]), 8'hA0 + i);
      chk("t6_last", int'(got_last[i]), int'(i == 3));
    end
    chk("t6_pkt_after", int'(pkt_count), 1);

    // 7: random writes and random backpressure
    clear_obs();
    exp_w.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        exp_w.push_back(DW'($urandom));
        fifo_mem.push_back(exp_w[exp_w.size() - 1]);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    m_ready = 1'b1;
    settle(200);
    chk("t7_count", got.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) chk("t7_data", int'(got[i]), int'(exp_w[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
